// File: rtl/sram_stream_reader.sv
// Block-read sequencer: walks an SRAM address range one word per cycle and
// streams the words out through a small credit-guarded FIFO.
module sram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  sram_enable,
  output logic                  sram_write,
  input  logic [DATA_WIDTH-1:0] sram_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  done_zero;
  logic                  accept, issue, drain_done, zero_cmd;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic                  push, pop;

  // sram_enable doubles as the in-flight flag: the word lands at the closing edge
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, sram_enable};
  assign push        = sram_enable;
  assign pop         = out_valid && out_ready;
  assign zero_cmd    = (state == IDLE) && start && (word_count == '0);

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: if (start && word_count != '0) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (remaining == '0)
          state_nxt = DRAIN;
        else if (credit_used < (CW+1)'(FIFO_DEPTH))
          issue = 1'b1;
      end
      DRAIN: if (fifo_count == '0 && !sram_enable) begin
        drain_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state        <= IDLE;
      ptr          <= '0;
      remaining    <= '0;
      done_zero    <= 1'b0;
      sram_enable  <= 1'b0;
      sram_address <= '0;
    end else begin
      state       <= state_nxt;
      done_zero   <= zero_cmd;
      sram_enable <= issue;
      if (accept) begin
        ptr       <= base_addr;
        remaining <= word_count;
      end else if (issue) begin
        sram_address <= ptr;
        ptr          <= ptr + 1'b1;
        remaining    <= remaining - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= sram_read_data;
  end

  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? fifo_mem[rd_ptr] : '0;
  assign busy       = (state != IDLE);
  assign done       = done_zero | drain_done;
  assign sram_write = 1'b0;
endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader: cycle-exact stream timing, address
// wrap, back-pressure, random ready, zero count, ignored start, mid-command reset.
module tb_sram_stream_reader;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_b, start, out_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          busy, done, sram_enable, sram_write, out_valid;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_read_data, out_data;

  logic [DW-1:0] mem [256];
  assign sram_read_data = mem[sram_address];

  always #5 clock = ~clock;

  sram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_b(reset_b), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .sram_address(sram_address), .sram_enable(sram_enable), .sram_write(sram_write),
    .sram_read_data(sram_read_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: inputs driven at negedge, sampled 2ns later, before the next posedge
  logic [DW-1:0] rx [$];
  logic [AW-1:0] addr_q [$];
  int done_cnt = 0, en_cnt = 0, wr_seen = 0, dv_clash = 0;

  always @(negedge clock) begin
    #2;
    if (reset_b) begin
      if (out_valid && out_ready) rx.push_back(out_data);
      if (done) done_cnt++;
      if (done && out_valid) dv_clash++;
      if (sram_enable) begin
        en_cnt++;
        addr_q.push_back(sram_address);
      end
      if (sram_write) wr_seen++;
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic start_cmd(input logic [AW-1:0] b, input logic [AW:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    chk(tag, 32'(ok), 1);
    step();
  endtask

  task automatic chk_rx(input string tag, input logic [AW-1:0] b, input int n);
    int errs;
    logic [AW-1:0] a;
    errs = 0;
    chk({tag, "_cnt"}, 32'(rx.size()), 32'(n));
    for (int i = 0; i < n && i < rx.size(); i++) begin
      a = b + AW'(i);
      if (rx[i] !== mem[a]) errs++;
    end
    chk({tag, "_data"}, 32'(errs), 0);
  endtask

  initial begin
    int d0, e0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h5A00 + 16'(a);
    for (int i = 0; i < 4; i++) mem[16 + i] = 16'hA000 + 16'(i);
    reset_b = 1'b0; start = 1'b0; out_ready = 1'b1; base_addr = '0; word_count = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en",   32'(sram_enable), 0);
    chk("rst_addr", 32'(sram_address), 0);
    chk("rst_wr",   32'(sram_write), 0);
    chk("rst_oval", 32'(out_valid), 0);
    reset_b = 1'b1;
    step();

    // Basic: cycle-exact timing, words A000..A003 from cycle 2
    rx.delete(); addr_q.delete();
    start_cmd(8'h10, 9'd4);
    chk("b_busy0", 32'(busy), 1);
    chk("b_oval0", 32'(out_valid), 0);
    chk("b_en0",   32'(sram_enable), 0);
    step();
    chk("b_en1",   32'(sram_enable), 1);
    chk("b_addr1", 32'(sram_address), 32'h10);
    chk("b_oval1", 32'(out_valid), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("b_oval", 32'(out_valid), 1);
      chk("b_data", 32'(out_data), 32'hA000 + i);
      step();
    end
    chk("b_done",  32'(done), 1);
    chk("b_ovd",   32'(out_valid), 0);
    chk("b_busyd", 32'(busy), 1);
    step();
    chk("b_busy7", 32'(busy), 0);
    chk("b_done7", 32'(done), 0);
    chk_rx("b_rx", 8'h10, 4);

    // Wrap across the top of the address space
    rx.delete(); addr_q.delete();
    start_cmd(8'hFE, 9'd4);
    wait_done("w_done", 20, 1'b0);
    chk("w_nadr", 32'(addr_q.size()), 4);
    if (addr_q.size() == 4) begin
      chk("w_a0", 32'(addr_q[0]), 32'hFE);
      chk("w_a1", 32'(addr_q[1]), 32'hFF);
      chk("w_a2", 32'(addr_q[2]), 32'h00);
      chk("w_a3", 32'(addr_q[3]), 32'h01);
    end
    chk_rx("w_rx", 8'hFE, 4);

    // Back-pressure: ready low for cycles 0..7
    rx.delete(); addr_q.delete(); en_cnt = 0;
    out_ready = 1'b0;
    start_cmd(8'h60, 9'd10);
    repeat (7) step();
    chk("bp_issued", 32'(en_cnt), 4);
    chk("bp_en",     32'(sram_enable), 0);
    chk("bp_oval",   32'(out_valid), 1);
    chk("bp_head",   32'(out_data), 32'h5A60);
    step();
    chk("bp_en8",    32'(sram_enable), 0);
    out_ready = 1'b1;
    wait_done("bp_done", 40, 1'b0);
    chk("bp_total", 32'(en_cnt), 10);
    chk_rx("bp_rx", 8'h60, 10);

    // Random ready over the full 256-word space
    rx.delete(); addr_q.delete(); d0 = done_cnt;
    start_cmd(8'h00, 9'h100);
    wait_done("r_done", 3000, 1'b1);
    repeat (3) step();
    chk("r_ndone", 32'(done_cnt - d0), 1);
    chk_rx("r_rx", 8'h00, 256);

    // Zero count, then a start pulse ignored mid-command
    d0 = done_cnt; e0 = en_cnt; rx.delete();
    start_cmd(8'h70, 9'd0);
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    step();
    chk("z_done1", 32'(done), 0);
    step();
    chk("z_noen", 32'(en_cnt - e0), 0);
    start_cmd(8'h20, 9'd3);
    step(); step();
    base_addr = 8'h40; word_count = 9'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ig_done", 20, 1'b0);
    repeat (3) step();
    chk("ig_busy", 32'(busy), 0);
    chk("ig_ndone", 32'(done_cnt - d0), 2);
    chk_rx("ig_rx", 8'h20, 3);

    // Reset in cycle 3 of an 8-word command
    d0 = done_cnt;
    start_cmd(8'h30, 9'd8);
    step(); step(); step();
    reset_b = 1'b0;
    step();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_en",   32'(sram_enable), 0);
    chk("mr_addr", 32'(sram_address), 0);
    chk("mr_oval", 32'(out_valid), 0);
    chk("mr_data", 32'(out_data), 0);
    reset_b = 1'b1;
    repeat (4) step();
    chk("mr_nodone", 32'(done_cnt - d0), 0);
    rx.delete();
    start_cmd(8'h50, 9'd2);
    wait_done("mr2_done", 20, 1'b0);
    chk_rx("mr2_rx", 8'h50, 2);

    chk("never_write", 32'(wr_seen), 0);
    chk("done_vs_valid", 32'(dv_clash), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_stream_reader.md
# sram_stream_reader

Read sequencer that sits directly upstream-facing on the read port of a generic single-port SRAM (combinational read, data settles within the cycle) and turns a block-read command into a valid/ready word stream for the CNN datapath (MAC array, weight/feature loaders). It issues one SRAM read per cycle while it has buffer credit, captures each word on the following clock edge, and buffers it in a small FIFO so that downstream back-pressure never loses data. It never writes the SRAM.

## Interface
- ADDR_WIDTH, 8, SRAM address width
- DATA_WIDTH, 16, SRAM word width
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)

- clock  in  1  rising-edge clock
- reset_b  in  1  synchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, latched on accepted start
- word_count  in  ADDR_WIDTH+1  words to read, 0..2^ADDR_WIDTH, latched on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at command completion
- sram_address  out  ADDR_WIDTH  registered read address
- sram_enable  out  1  registered read enable
- sram_write  out  1  tied 0
- sram_read_data  in  DATA_WIDTH  SRAM read data
- out_data  out  DATA_WIDTH  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accept; transfer when out_valid && out_ready

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start && word_count≠0 → latch ptr=base_addr, remaining=word_count, go RUN. start && word_count==0 → done pulse next cycle, stay IDLE, no SRAM access. start while busy ignored.
- RUN: issue when remaining>0 and (fifo_count + inflight) < FIFO_DEPTH (registered values): next cycle sram_enable=1, sram_address=ptr; ptr increments mod 2^ADDR_WIDTH (wrap 0xFF→0x00 for default); remaining decrements. No issue → sram_enable=0, sram_address holds. remaining reaches 0 → DRAIN.
- inflight: 1 in the cycle sram_enable is high; sram_read_data is captured into the FIFO at the closing edge of that cycle.
- DRAIN: when fifo_count==0 and inflight==0 → done pulse, IDLE.
- FIFO: push on capture, pop on out_valid && out_ready; simultaneous push/pop leaves count unchanged; never overflows (credit rule); out_data stable while out_valid && !out_ready.
- Words emitted in address order, exactly word_count per command.

## Timing
- Reset (reset_b low at an edge): state IDLE, busy 0, done 0, sram_enable 0, sram_address 0, sram_write 0, out_valid 0, FIFO and counters cleared. Reset mid-command aborts it: buffered words discarded, no done.
- out_ready held 1, word_count=N, start sampled at edge 0: busy high after edge 0; sram_enable high edges 1..N+1 with address base+k-1 in cycle k; word k captured at edge k+1, out_valid in cycle k+1, popped at edge k+2; done high for the single cycle after edge N+2; busy low after edge N+3 (busy includes the done cycle).
- Sustained throughput 1 word/cycle with out_ready=1; first-word latency 2 cycles from start.
- Back-pressure: at most FIFO_DEPTH words buffered plus 0 in flight when full; issue resumes the cycle after a pop frees credit.
- done is never asserted together with out_valid.

## Test plan
- Basic: mem[0x10..0x13]=0xA000..0xA003, start base=0x10 count=4, out_ready=1 → out_data 0xA000,0xA001,0xA002,0xA003 on consecutive cycles from cycle 2; done one cycle after last pop; sram_write never 1.
- Wrap: base=0xFE count=4 → addresses 0xFE,0xFF,0x00,0x01 issued, words in that order.
- Back-pressure: count=10, out_ready low for 8 cycles after start → exactly 4 words buffered, sram_enable low until ready returns; all 10 words delivered in order, no duplicates.
- Random out_ready (50%) over count=256 base=0x00 → 256 words matching mem[0..255]; done exactly once.
- Zero count and ignored start: count=0 → done next cycle, no sram_enable; start pulsed mid-command → no effect on stream or counts.
- Reset at cycle 3 of count=8 → all outputs 0 next cycle, no done; subsequent command count=2 completes normally.
